// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: drives a variable-latency dmem handshake,
// stalls the pipeline while an access is outstanding, extends load data.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            berr_q, berr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;

  logic            mem_op;
  logic            mis;
  logic            acc;
  logic [1:0]      sz;
  logic [3:0]      be_nxt;
  logic [31:0]     wdata_nxt;
  logic            timeout_hit;

  // Byte/half lane select followed by sign or zero extension.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] off,
                                         input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extend = {{24{b[7]}}, b};
      3'b001:  extend = {{16{h[15]}}, h};
      3'b100:  extend = {24'b0, b};
      3'b101:  extend = {16'b0, h};
      default: extend = w;
    endcase
  endfunction

  // Loads and stores share the size encoding in funct3[1:0]: 00 byte, 01 half, 1x word.
  always_comb begin
    mem_op     = mem_read | mem_write;
    sz         = funct3[1:0];
    mis        = ((sz == 2'b01) & addr[0]) | (sz[1] & (addr[1:0] != 2'b00));
    acc        = mem_valid & mem_op & ~mis;
    misaligned = mem_valid & mem_op & mis;

    be_nxt    = 4'b1111;
    wdata_nxt = store_data;
    if (mem_write) begin
      case (sz)
        2'b00: begin
          be_nxt    = 4'b0001 << addr[1:0];
          wdata_nxt = {4{store_data[7:0]}};
        end
        2'b01: begin
          be_nxt    = 4'b0011 << {addr[1], 1'b0};
          wdata_nxt = {2{store_data[15:0]}};
        end
        default: begin
          be_nxt    = 4'b1111;
          wdata_nxt = store_data;
        end
      endcase
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    berr_d  = berr_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    f3_d    = f3_q;
    stall   = 1'b0;

    case (state_q)
      IDLE: begin
        stall = acc;
        if (acc) begin
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = {addr[31:2], 2'b00};
          wdata_d = wdata_nxt;
          be_d    = be_nxt;
          cnt_d   = '0;
          off_d   = addr[1:0];
          f3_d    = funct3;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dmem_ack) begin
          req_d = 1'b0;
          if (!we_q) rdata_d = extend(dmem_rdata, off_q, f3_q);
          state_d = DONE;
        end else if (timeout_hit) begin
          req_d  = 1'b0;
          berr_d = 1'b1;
          if (!we_q) rdata_d = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        berr_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      berr_q  <= 1'b0;
      cnt_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign read_data  = rdata_q;
  assign bus_error  = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, slow ack,
// timeout and asynchronous reset during an access.
module tb_mem_access_unit;

  logic        clk;
  logic        reset_n;
  logic        mem_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] read_data;
  logic        stall;
  logic        misaligned;
  logic        bus_error;

  int n_assert = 0;
  int n_fail   = 0;

  int stalls, reqc, unstable;
  logic berr, mis;

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_valid  (mem_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .read_data  (read_data),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_error  (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one MEM-stage instruction, acks in BUSY cycle ack_k (0 = never),
  // and reports stalled cycles, req-high cycles, and DONE-cycle bus_error.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int ack_k, input logic [31:0] rdata,
                        output int st, output int rq, output int unst,
                        output logic be_done, output logic mis_seen);
    logic [31:0] a0;
    st = 0; rq = 0; unst = 0; a0 = '0;
    mem_valid = 1'b1; mem_read = rd; mem_write = wr;
    funct3 = f3; addr = a; store_data = sd;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (dmem_req) begin
        rq++;
        if (rq == 1) a0 = dmem_addr;
        else if (dmem_addr !== a0) unst++;
        if (rq == ack_k) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdata;
        end
      end
      if (!stall) break;
      st++;
      tick();
      dmem_ack = 1'b0;
      dmem_rdata = 32'h5A5A_5A5A;
    end
    be_done  = bus_error;
    mis_seen = misaligned;
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; addr = '0; store_data = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;

    #2;
    chk("reset_req",   {31'b0, dmem_req}, 32'h0);
    chk("reset_rdata", read_data, 32'h0);
    chk("reset_addr",  dmem_addr, 32'h0);
    chk("reset_be",    {28'b0, dmem_be}, 32'h0);
    #20 reset_n = 1'b1;
    tick();

    // LB from 0x103, top byte 0x80 -> sign extended
    access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234, stalls, reqc, unstable, berr, mis);
    chk("lb_stall_cycles", stalls, 2);
    chk("lb_req_cycles",   reqc, 1);
    chk("lb_data",         read_data, 32'hFFFF_FF80);
    chk("lb_addr",         dmem_addr, 32'h0000_0100);
    chk("lb_be",           {28'b0, dmem_be}, 32'hF);
    chk("lb_we",           {31'b0, dmem_we}, 32'h0);

    access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234, stalls, reqc, unstable, berr, mis);
    chk("lbu_stall_cycles", stalls, 2);
    chk("lbu_data",         read_data, 32'h0000_0080);

    // SH to 0x2002: upper half lanes, replicated data; read_data untouched
    access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 1, 32'h1111_1111, stalls, reqc, unstable, berr, mis);
    chk("sh_stall_cycles", stalls, 2);
    chk("sh_addr",  dmem_addr, 32'h0000_2000);
    chk("sh_be",    {28'b0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we",    {31'b0, dmem_we}, 32'h1);
    chk("sh_rdata_held", read_data, 32'h0000_0080);

    access(1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h1234_56CD, 2, 32'h0, stalls, reqc, unstable, berr, mis);
    chk("sb_stall_cycles", stalls, 3);
    chk("sb_be",    {28'b0, dmem_be}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hCDCD_CDCD);

    // read+write together is a write
    access(1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 1, 32'h2222_2222, stalls, reqc, unstable, berr, mis);
    chk("rw_we",    {31'b0, dmem_we}, 32'h1);
    chk("rw_wdata", dmem_wdata, 32'hCAFE_F00D);
    chk("rw_rdata_held", read_data, 32'h0000_0080);

    // LH from upper half, sign extended
    access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 1, 32'h80FF_1234, stalls, reqc, unstable, berr, mis);
    chk("lh_data", read_data, 32'hFFFF_80FF);

    // misaligned LW and LH: no request, no stall
    access(1'b1, 1'b0, 3'b010, 32'h0000_1001, 32'h0, 1, 32'h0, stalls, reqc, unstable, berr, mis);
    chk("mis_lw_flag",  {31'b0, mis}, 32'h1);
    chk("mis_lw_stall", stalls, 0);
    chk("mis_lw_req",   reqc, 0);
    chk("mis_lw_req_after", {31'b0, dmem_req}, 32'h0);
    access(1'b1, 1'b0, 3'b001, 32'h0000_1003, 32'h0, 1, 32'h0, stalls, reqc, unstable, berr, mis);
    chk("mis_lh_flag",  {31'b0, mis}, 32'h1);
    chk("mis_lh_stall", stalls, 0);
    chk("mis_lh_req",   reqc, 0);
    chk("mis_rdata_held", read_data, 32'hFFFF_80FF);

    // LW with ack in the 5th BUSY cycle
    access(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5, 32'hDEAD_BEEF, stalls, reqc, unstable, berr, mis);
    chk("lw5_stall_cycles", stalls, 6);
    chk("lw5_req_cycles",   reqc, 5);
    chk("lw5_addr_stable",  unstable, 0);
    chk("lw5_data",         read_data, 32'hDEAD_BEEF);
    chk("lw5_no_berr",      {31'b0, berr}, 32'h0);

    // no ack: abandoned after 16 BUSY cycles
    access(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 0, 32'h0, stalls, reqc, unstable, berr, mis);
    chk("to_req_cycles",   reqc, 16);
    chk("to_stall_cycles", stalls, 17);
    chk("to_berr_done",    {31'b0, berr}, 32'h1);
    chk("to_berr_cleared", {31'b0, bus_error}, 32'h0);
    chk("to_rdata_zero",   read_data, 32'h0);
    chk("to_req_low",      {31'b0, dmem_req}, 32'h0);

    access(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 1, 32'h1357_9BDF, stalls, reqc, unstable, berr, mis);
    chk("lw1_data", read_data, 32'h1357_9BDF);

    // stray ack while idle is ignored
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_ack = 1'b0;
    chk("idle_ack_rdata", read_data, 32'h1357_9BDF);
    chk("idle_ack_req",   {31'b0, dmem_req}, 32'h0);
    chk("idle_ack_stall", {31'b0, stall}, 32'h0);

    // reset while BUSY
    mem_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_6000;
    tick();
    chk("rst_busy_req", {31'b0, dmem_req}, 32'h1);
    #2 reset_n = 1'b0;
    mem_valid = 1'b0; mem_read = 1'b0;
    #1;
    chk("rst_req_async", {31'b0, dmem_req}, 32'h0);
    chk("rst_addr",      dmem_addr, 32'h0);
    chk("rst_rdata",     read_data, 32'h0);
    chk("rst_stall",     {31'b0, stall}, 32'h0);
    #3 reset_n = 1'b1;
    tick();
    tick();
    chk("post_rst_stall", {31'b0, stall}, 32'h0);
    chk("post_rst_req",   {31'b0, dmem_req}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data access controller for the RV32I pipeline, sitting between the EX/MEM pipeline register and the MEM/WB register. It turns EX/MEM load/store controls into word-aligned requests on a variable-latency data-memory handshake bus. It generates byte enables and lane-replicated store data, and sign/zero-extends load data onto `read_data`, which feeds MEM/WB `MEM_ReadMemData`. While an access is outstanding it stalls the pipeline. It also flags misaligned accesses and bus timeouts.

## Interface
- `TIMEOUT_CYCLES`, default 16: BUSY cycles without `dmem_ack` before the access is abandoned; 0 disables the timeout.
- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `mem_valid`  in  1  valid instruction in MEM stage
- `mem_read` / `mem_write`  in  1 each  load / store control
- `funct3`  in  3  RV32I width/sign field
- `addr`  in  32  byte address (ALU result)
- `store_data`  in  32  rs2 value
- `dmem_req`  out  1  request, held until ack
- `dmem_we`  out  1  1 = write
- `dmem_addr`  out  32  `{addr[31:2],2'b00}`
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_be`  out  4  byte enables
- `dmem_ack`  in  1  one-cycle completion strobe
- `dmem_rdata`  in  32  read word, valid with ack
- `read_data`  out  32  extended load result to MEM/WB
- `stall`  out  1  hold PC, IF/ID, ID/EX, EX/MEM, MEM/WB
- `misaligned`  out  1  misaligned access present (combinational)
- `bus_error`  out  1  one-cycle pulse on timeout

## Operation
- **acc** = `mem_valid & (mem_read | mem_write) & !mis`.
- **Write priority:** `mem_read & mem_write` is treated as a write.
- **Misalignment:**
  - `mis` for halfword when `addr[0]`.
  - `mis` for word when `addr[1:0] != 0`.
- **Load `funct3`:** 000 LB, 001 LH, 100 LBU, 101 LHU; all other codes are LW.
- **Store `funct3[1:0]`:** 00 SB, 01 SH, 1x SW.
- **Stores:**
  - SB: be = `4'b0001 << addr[1:0]`, wdata = `{4{sd[7:0]}}`.
  - SH: be = `4'b0011 << {addr[1],1'b0}`, wdata = `{2{sd[15:0]}}`.
  - SW: be = `1111`, wdata = `sd`.
- **Loads:** be = `1111`, we = 0. The byte/half is selected by `addr[1:0]`, then sign- or zero-extended per `funct3`.
- **FSM states:** IDLE, BUSY, DONE.
  - IDLE: `stall = acc`. If acc, register `dmem_addr`/`we`/`be`/`wdata`, set `dmem_req` = 1, clear the timeout counter, go to BUSY.
  - BUSY: `stall` = 1. Outputs are stable while `dmem_req` is high.
    - On `dmem_ack`: `dmem_req` <= 0, `read_data` <= extended `dmem_rdata` (loads only; stores leave `read_data` unchanged), go to DONE.
    - Timeout: `TIMEOUT_CYCLES != 0` and ack still low in the TIMEOUT_CYCLES-th BUSY cycle. Then `dmem_req` <= 0, `read_data` <= 0 for a load, `bus_error` <= 1, go to DONE.
  - DONE: `stall` = 0, the pipeline advances, and MEM/WB captures `read_data`. `bus_error` clears at the end of DONE. Go to IDLE.
- **Load context:** the load's `addr[1:0]` and `funct3` are latched at request time for extension.
- **Changing inputs:** changes to `mem_valid` or other inputs during BUSY are ignored. A request is never aborted except by reset.
- **Misaligned access:** issues no request and no stall. The instruction passes through with `misaligned` = 1 for that cycle; the trap/flush logic kills it.
- **Non-memory instructions:** no stall, and `read_data` holds its last value.

## Timing
- **Reset values:** all registered outputs are 0 (`dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_be`, `read_data`, `bus_error`). FSM = IDLE.
- **Reset mid-access:** `dmem_req` drops immediately (asynchronous). The memory side tolerates abandoned requests.
- **Latency:** with ack in BUSY cycle k, an access occupies 2+k cycles and `stall` is high for 1+k cycles. Minimum is 3 cycles with 2 stalled.
- **Ack qualification:** `dmem_ack` is sampled only in BUSY. An ack in IDLE or DONE is ignored.
- **Back-to-back accesses:** the next access is first seen in the IDLE cycle after DONE.

## Test plan
- LB, addr 0x103, rdata 0x80FF1234, ack in first BUSY cycle -> `read_data` 0xFFFFFF80, stall high exactly 2 cycles. The same access with LBU -> 0x00000080.
- SH, addr 0x2002, store_data 0x0000ABCD -> `dmem_addr` 0x2000, be 1100, wdata 0xABCDABCD, we 1. SB to 0x2001 -> be 0010.
- LW at 0x1001 and LH at 0x1003 -> `misaligned` 1, `dmem_req` never rises, stall 0.
- LW with ack in 5th BUSY cycle -> req/addr/be stable for 5 cycles, stall 6 cycles, rdata 0xDEADBEEF on `read_data` in DONE.
- TIMEOUT_CYCLES=16, no ack -> req drops after 16 BUSY cycles, 1-cycle `bus_error` in DONE, `read_data` 0.
- `reset_n` low during BUSY -> `dmem_req` 0 same cycle, all outputs 0. After release, stall 0 with no access pending.
